// File: rtl/game_next_gen_if.sv
// game_next_gen_if : field-latch handshake between the generation engine and its field register.
// Rev 1.0
`default_nettype none

interface game_next_gen_if #(
  parameter int WIDTH  = 40,
  parameter int HEIGHT = 30
);
  logic                          step;
  logic [HEIGHT-1:0][WIDTH-1:0]  game_field_old;
  logic [HEIGHT-1:0][WIDTH-1:0]  game_field_new;
  logic                          new_game_field_vld;
  logic                          busy;
  logic                          field_changed;
  logic [15:0]                   gen_count;

  // master: the controller/field register side; slave: the generation engine
  modport master (
    output step,
    output game_field_old,
    input  game_field_new,
    input  new_game_field_vld,
    input  busy,
    input  field_changed,
    input  gen_count
  );

  modport slave (
    input  step,
    input  game_field_old,
    output game_field_new,
    output new_game_field_vld,
    output busy,
    output field_changed,
    output gen_count
  );
endinterface

`default_nettype wire

// File: rtl/game_next_gen.sv
// game_next_gen : Conway B3/S23 next-generation engine, one row per clock (HEIGHT+1 cycles per step).
// Rev 1.0
`default_nettype none

module game_next_gen #(
  parameter int WIDTH  = 40,
  parameter int HEIGHT = 30,
  parameter int WRAP   = 1
) (
  input  wire logic       clk,
  input  wire logic       rst,
  game_next_gen_if.slave  bus
);

  localparam int                 c_ROW_W     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [c_ROW_W-1:0] c_LAST_ROW  = c_ROW_W'(HEIGHT - 1);
  localparam bit                 c_DEAD_EDGE = (WRAP == 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [c_ROW_W-1:0]            r_row;
  logic [HEIGHT-1:0][WIDTH-1:0]  r_field_new;
  logic                          r_diff;
  logic                          r_changed;
  logic [15:0]                   r_gen;

  logic                          w_busy;
  logic                          w_vld;
  logic                          w_last_row;
  logic [c_ROW_W-1:0]            w_row_up;
  logic [c_ROW_W-1:0]            w_row_dn;
  logic [WIDTH-1:0]              w_up;
  logic [WIDTH-1:0]              w_mid;
  logic [WIDTH-1:0]              w_dn;
  logic [WIDTH-1:0]              w_new_row;

  // Neighbour rows of the current row, with wrap or dead boundaries
  always_comb begin
    w_last_row = (r_row == c_LAST_ROW);
    w_row_up   = (r_row == '0) ? c_LAST_ROW : (r_row - c_ROW_W'(1));
    w_row_dn   = w_last_row ? '0 : (r_row + c_ROW_W'(1));
    w_mid      = bus.game_field_old[r_row];
    w_up       = (c_DEAD_EDGE && (r_row == '0)) ? '0 : bus.game_field_old[w_row_up];
    w_dn       = (c_DEAD_EDGE && w_last_row)    ? '0 : bus.game_field_old[w_row_dn];
  end

  generate
    for (genvar c = 0; c < WIDTH; c++) begin : g_col
      localparam int c_COL_L  = (c == 0) ? (WIDTH - 1) : (c - 1);
      localparam int c_COL_R  = (c == WIDTH - 1) ? 0 : (c + 1);
      localparam bit c_DEAD_L = c_DEAD_EDGE && (c == 0);
      localparam bit c_DEAD_R = c_DEAD_EDGE && (c == WIDTH - 1);

      logic [2:0] w_left;
      logic [2:0] w_right;
      logic [7:0] w_nb;
      logic [3:0] w_cnt;

      assign w_left  = c_DEAD_L ? 3'b000 : {w_up[c_COL_L], w_mid[c_COL_L], w_dn[c_COL_L]};
      assign w_right = c_DEAD_R ? 3'b000 : {w_up[c_COL_R], w_mid[c_COL_R], w_dn[c_COL_R]};
      assign w_nb    = {w_left, w_right, w_up[c], w_dn[c]};

      always_comb begin
        w_cnt = 4'd0;
        for (int k = 0; k < 8; k++) begin
          w_cnt = w_cnt + {3'b000, w_nb[k]};
        end
      end

      assign w_new_row[c] = (w_cnt == 4'd3) | (w_mid[c] & (w_cnt == 4'd2));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_vld       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.step) begin
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        w_busy = 1'b1;
        if (w_last_row) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_busy      = 1'b1;
        w_vld       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row       <= '0;
      r_field_new <= '0;
      r_diff      <= 1'b0;
      r_changed   <= 1'b0;
      r_gen       <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.step) begin
            r_row  <= '0;
            r_diff <= 1'b0;
          end
        end
        S_CALC: begin
          r_field_new[r_row] <= w_new_row;
          r_diff             <= r_diff | (|(w_new_row ^ w_mid));
          if (!w_last_row) begin
            r_row <= r_row + c_ROW_W'(1);
          end
        end
        S_DONE: begin
          r_changed <= r_diff;
          r_gen     <= r_gen + 16'd1;
        end
        default: begin
          r_row <= '0;
        end
      endcase
    end
  end

  assign bus.game_field_new     = r_field_new;
  assign bus.new_game_field_vld = w_vld;
  assign bus.busy               = w_busy;
  assign bus.field_changed      = r_changed;
  assign bus.gen_count          = r_gen;

endmodule

`default_nettype wire

// File: tb/tb_game_next_gen.sv
// tb_game_next_gen : random and directed checks of game_next_gen (WRAP=1 and WRAP=0) against a cell-rule model.
// Rev 1.0
`default_nettype none

module tb_game_next_gen;

  localparam int WIDTH  = 40;
  localparam int HEIGHT = 30;

  typedef logic [HEIGHT-1:0][WIDTH-1:0] field_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_gen  = 0;

  always #5 clk = ~clk;

  game_next_gen_if #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) bus_w ();
  game_next_gen_if #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) bus_d ();

  game_next_gen #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .WRAP(1)) u_dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus_w)
  );

  game_next_gen #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .WRAP(0)) u_dut_dead (
    .clk (clk),
    .rst (rst),
    .bus (bus_d)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One comparison per field, reporting the first row that differs
  task automatic check_field(input string tag, input field_t got, input field_t exp);
    int bad;
    bad = 0;
    for (int r = HEIGHT - 1; r >= 0; r--) begin
      if (got[r] !== exp[r]) bad = r;
    end
    check($sformatf("%s.row%0d", tag, bad), 64'(got[bad]), 64'(exp[bad]));
  endtask

  // Reference: every cell counts its eight surrounding cells by plain index arithmetic
  function automatic field_t life(input field_t f, input bit wrap);
    field_t n;
    int     cnt, rr, cc;
    n = '0;
    for (int r = 0; r < HEIGHT; r++) begin
      for (int c = 0; c < WIDTH; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr == 0 && dc == 0) continue;
            rr = r + dr;
            cc = c + dc;
            if (wrap) begin
              rr = (rr + HEIGHT) % HEIGHT;
              cc = (cc + WIDTH) % WIDTH;
            end else if (rr < 0 || rr >= HEIGHT || cc < 0 || cc >= WIDTH) begin
              continue;
            end
            cnt += int'(f[rr][cc]);
          end
        end
        n[r][c] = (cnt == 3) || (f[r][c] && cnt == 2);
      end
    end
    return n;
  endfunction

  function automatic field_t rand_field(input int pct);
    field_t f;
    for (int r = 0; r < HEIGHT; r++)
      for (int c = 0; c < WIDTH; c++)
        f[r][c] = ($urandom_range(99) < pct);
    return f;
  endfunction

  task automatic set_step(input logic v);
    bus_w.step = v;
    bus_d.step = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_step(1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_gen = 0;
  endtask

  // One full generation on both engines; called and returns at a falling edge
  task automatic do_gen(input field_t f_w, input field_t f_d, input string tag);
    field_t e_w, e_d;
    int     cyc;
    e_w = life(f_w, 1'b1);
    e_d = life(f_d, 1'b0);
    bus_w.game_field_old = f_w;
    bus_d.game_field_old = f_d;
    @(negedge clk);
    set_step(1'b1);
    @(negedge clk);
    set_step(1'b0);
    cyc = 1;
    check({tag, ".busy_acc"}, 64'(bus_w.busy), 64'd1);
    while (!bus_w.new_game_field_vld && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".latency"}, 64'(cyc), 64'd31);
    check({tag, ".vld_dead"}, 64'(bus_d.new_game_field_vld), 64'd1);
    check({tag, ".busy_vld"}, 64'(bus_w.busy), 64'd1);
    check_field({tag, ".new_wrap"}, bus_w.game_field_new, e_w);
    check_field({tag, ".new_dead"}, bus_d.game_field_new, e_d);
    @(negedge clk);
    exp_gen = (exp_gen + 1) & 16'hFFFF;
    check({tag, ".vld_off"}, 64'(bus_w.new_game_field_vld), 64'd0);
    check({tag, ".busy_off"}, 64'(bus_w.busy), 64'd0);
    check({tag, ".gen_wrap"}, 64'(bus_w.gen_count), 64'(exp_gen));
    check({tag, ".gen_dead"}, 64'(bus_d.gen_count), 64'(exp_gen));
    check({tag, ".chg_wrap"}, 64'(bus_w.field_changed), 64'(e_w != f_w));
    check({tag, ".chg_dead"}, 64'(bus_d.field_changed), 64'(e_d != f_d));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    field_t f, g, exp_f, fw, fd;
    int     vld_cyc[$];
    int     busy_low, k;
    bit     saw_vld;

    bus_w.game_field_old = '0;
    bus_d.game_field_old = '0;
    do_reset();

    check_field("rst.new", bus_w.game_field_new, '0);
    check_field("rst.new_dead", bus_d.game_field_new, '0);
    check("rst.vld", 64'(bus_w.new_game_field_vld), 64'd0);
    check("rst.busy", 64'(bus_w.busy), 64'd0);
    check("rst.chg", 64'(bus_w.field_changed), 64'd0);
    check("rst.gen", 64'(bus_w.gen_count), 64'd0);

    // Blinker
    f = '0;
    f[5][10] = 1'b1; f[5][11] = 1'b1; f[5][12] = 1'b1;
    exp_f = '0;
    exp_f[4][11] = 1'b1; exp_f[5][11] = 1'b1; exp_f[6][11] = 1'b1;
    do_gen(f, f, "blinker");
    check_field("blinker.spec", bus_w.game_field_new, exp_f);
    check("blinker.chg", 64'(bus_w.field_changed), 64'd1);
    check("blinker.gen", 64'(bus_w.gen_count), 64'd1);

    // Still-life block and empty field
    f = '0;
    f[8][20] = 1'b1; f[8][21] = 1'b1; f[9][20] = 1'b1; f[9][21] = 1'b1;
    do_gen(f, f, "block");
    check_field("block.spec", bus_w.game_field_new, f);
    check("block.chg", 64'(bus_w.field_changed), 64'd0);
    do_gen('0, '0, "empty");
    check_field("empty.spec", bus_w.game_field_new, '0);

    // Corner blinker straddling the column wrap
    f = '0;
    f[0][39] = 1'b1; f[0][0] = 1'b1; f[0][1] = 1'b1;
    exp_f = '0;
    exp_f[29][0] = 1'b1; exp_f[0][0] = 1'b1; exp_f[1][0] = 1'b1;
    do_gen(f, f, "corner");
    check_field("corner.spec_wrap", bus_w.game_field_new, exp_f);
    check_field("corner.spec_dead", bus_d.game_field_new, '0);

    // Random fields of varying density
    for (int i = 0; i < 6; i++) begin
      do_gen(rand_field(15 + 10 * i), rand_field(20 + 8 * i), $sformatf("rand%0d", i));
    end

    // Step held high for 70 cycles: requests while busy are dropped
    f = rand_field(35);
    bus_w.game_field_old = f;
    bus_d.game_field_old = f;
    @(negedge clk);
    busy_low = 0;
    set_step(1'b1);
    for (int i = 0; i < 70; i++) begin
      if (!bus_w.busy) busy_low++;
      if (bus_w.new_game_field_vld) vld_cyc.push_back(i);
      @(negedge clk);
    end
    set_step(1'b0);
    check("hold.vld_count", 64'(vld_cyc.size()), 64'd2);
    if (vld_cyc.size() >= 2) begin
      check("hold.first_vld", 64'(vld_cyc[0]), 64'd31);
      check("hold.spacing", 64'(vld_cyc[1] - vld_cyc[0]), 64'd32);
    end
    check("hold.busy_low", 64'(busy_low), 64'd3);
    k = 0;
    while (bus_w.busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("hold.drain", 64'(bus_w.busy), 64'd0);
    exp_gen += 3;
    check("hold.gen", 64'(bus_w.gen_count), 64'(exp_gen));
    check_field("hold.new", bus_w.game_field_new, life(f, 1'b1));

    // Reset during CALC aborts the generation
    f = rand_field(40);
    bus_w.game_field_old = f;
    bus_d.game_field_old = f;
    @(negedge clk);
    set_step(1'b1);
    @(negedge clk);
    set_step(1'b0);
    saw_vld = 1'b0;
    repeat (14) begin
      @(negedge clk);
      saw_vld |= bus_w.new_game_field_vld;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_gen = 0;
    check_field("abort.new_wrap", bus_w.game_field_new, '0);
    check_field("abort.new_dead", bus_d.game_field_new, '0);
    check("abort.gen", 64'(bus_w.gen_count), 64'd0);
    check("abort.busy", 64'(bus_w.busy), 64'd0);
    repeat (40) begin
      @(negedge clk);
      saw_vld |= bus_w.new_game_field_vld;
    end
    check("abort.no_vld", 64'(saw_vld), 64'd0);
    do_gen(f, f, "after_abort");

    // Glider in closed loop with the field latch
    do_reset();
    g = '0;
    g[2][6] = 1'b1; g[3][7] = 1'b1; g[4][5] = 1'b1; g[4][6] = 1'b1; g[4][7] = 1'b1;
    fw = g;
    fd = g;
    for (int i = 0; i < 160; i++) begin
      do_gen(fw, fd, "glider");
      fw = bus_w.game_field_new;
      fd = bus_d.game_field_new;
    end
    exp_f = '0;
    exp_f[12][6] = 1'b1; exp_f[13][7] = 1'b1; exp_f[14][5] = 1'b1;
    exp_f[14][6] = 1'b1; exp_f[14][7] = 1'b1;
    check_field("glider.final", fw, exp_f);
    check("glider.gen", 64'(bus_w.gen_count), 64'd160);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
